// File: rtl/lsu_pkg.sv
// ----------------------------------------------------------------------------
// lsu_pkg
//   Shared encodings for the load/store unit: access-size codes, the
//   mem_wr_rd polarity, the FSM state type, the latched request control
//   word, and the address-offset helpers used for alignment handling.
// ----------------------------------------------------------------------------
package lsu_pkg;

    // req_size encoding
    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_RSVD = 2'b11;

    // mem_wr_rd encoding
    localparam logic WR_RD_WRITE = 1'b0;
    localparam logic WR_RD_READ  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ADDR = 2'b01,
        ST_DATA = 2'b10,
        ST_RESP = 2'b11
    } lsu_state_e;

    // Control fields captured when a request is accepted.
    typedef struct packed {
        logic       we;
        logic [1:0] size;
        logic       sgn;
        logic       err;
    } lsu_ctrl_t;

    // True when the byte offset is not a multiple of the access size.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        return ((size == SIZE_HALF) && off[0]) ||
               ((size == SIZE_WORD) && (off != 2'b00));
    endfunction

    // Clears the offset bits below the access size.
    function automatic logic [1:0] align_off(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SIZE_HALF: return {off[1], 1'b0};
            SIZE_WORD: return 2'b00;
            default:   return off;
        endcase
    endfunction

endpackage

// File: rtl/load_store_align.sv
// ----------------------------------------------------------------------------
// load_store_align
//   Purely combinational lane logic for the load/store unit.
//   Ports:
//     size, sgn, offset  - access size, sign-extend flag, byte offset in word
//     rdata              - word read from memory
//     wdata              - store data, right-aligned
//     load_data          - selected lane, zero/sign-extended to DATA_WIDTH
//     store_data         - rdata with the addressed lanes replaced by wdata
//   Offsets are expected to be already aligned to the access size; a word
//   access therefore always arrives with offset 0.
// ----------------------------------------------------------------------------
module load_store_align
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [1:0]            size,
    input  logic                  sgn,
    input  logic [1:0]            offset,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] load_data,
    output logic [DATA_WIDTH-1:0] store_data
);

    logic [4:0]            byte_sh;
    logic [4:0]            half_sh;
    logic [7:0]            byte_v;
    logic [15:0]           half_v;
    logic [DATA_WIDTH-1:0] lane_mask;

    assign byte_sh = {offset, 3'b000};
    assign half_sh = {offset[1], 4'b0000};
    assign byte_v  = rdata[byte_sh +: 8];
    assign half_v  = rdata[half_sh +: 16];

    always_comb begin
        load_data = rdata;
        lane_mask = '1;
        case (size)
            SIZE_BYTE: begin
                load_data = {{(DATA_WIDTH-8){sgn & byte_v[7]}}, byte_v};
                lane_mask = {{(DATA_WIDTH-8){1'b0}}, 8'hFF} << byte_sh;
            end
            SIZE_HALF: begin
                load_data = {{(DATA_WIDTH-16){sgn & half_v[15]}}, half_v};
                lane_mask = {{(DATA_WIDTH-16){1'b0}}, 16'hFFFF} << half_sh;
            end
            default: ;
        endcase
    end

    // Word accesses have offset 0 and an all-ones mask, so wdata passes
    // straight through the same merge.
    assign store_data = (rdata & ~lane_mask) | ((wdata << byte_sh) & lane_mask);

endmodule

// File: rtl/load_store_unit.sv
// ----------------------------------------------------------------------------
// load_store_unit
//   Byte/half/word load-store front end for a word-addressed synchronous
//   memory. Each request walks IDLE -> ADDR -> DATA -> RESP; stores are done
//   as read-modify-write in DATA. Rejected requests go IDLE -> RESP directly
//   and never touch memory.
//   Ports:
//     clk, rst                 - clock, asynchronous active-high reset
//     req_*                    - request handshake (accepted only in IDLE)
//     resp_valid/rdata/err     - one-cycle completion, held load result, reject
//     mem_addr/wr_rd/data_in   - memory word index, 0=write 1=read, write data
//     mem_data_out             - memory read data (one cycle after address)
//   Configuration:
//     LSU_ALIGN_CHECK_EN defined   - misaligned half/word requests are rejected
//     LSU_ALIGN_CHECK_EN undefined - offset bits below the size are cleared
// ----------------------------------------------------------------------------
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [ADDR_WIDTH+1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_wr_rd,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    input  logic [DATA_WIDTH-1:0] mem_data_out
);

    lsu_state_e            state_q, state_d;
    lsu_ctrl_t             ctrl_q;
    logic [ADDR_WIDTH+1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic                  req_err;
    logic [ADDR_WIDTH+1:0] req_addr_eff;
    logic                  accept;
    logic [DATA_WIDTH-1:0] load_data;
    logic [DATA_WIDTH-1:0] store_data;

    assign accept = (state_q == ST_IDLE) && req_valid;

    // Request screening and effective address.
    always_comb begin
        req_addr_eff = req_addr;
        req_err      = (req_size == SIZE_RSVD);
`ifdef LSU_ALIGN_CHECK_EN
        req_err      = req_err | misaligned(req_size, req_addr[1:0]);
`else
        req_addr_eff[1:0] = align_off(req_size, req_addr[1:0]);
`endif
    end

    load_store_align #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_align (
        .size       (ctrl_q.size),
        .sgn        (ctrl_q.sgn),
        .offset     (addr_q[1:0]),
        .rdata      (mem_data_out),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .store_data (store_data)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (req_valid) state_d = req_err ? ST_RESP : ST_ADDR;
            ST_ADDR: state_d = ST_DATA;
            ST_DATA: state_d = ST_RESP;
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        req_ready   = (state_q == ST_IDLE);
        resp_valid  = (state_q == ST_RESP);
        resp_err    = (state_q == ST_RESP) && ctrl_q.err;
        mem_addr    = addr_q[ADDR_WIDTH+1:2];
        mem_wr_rd   = WR_RD_READ;
        mem_data_in = '0;
        if ((state_q == ST_DATA) && ctrl_q.we) begin
            mem_wr_rd   = WR_RD_WRITE;
            mem_data_in = store_data;
        end
    end

    // Request capture. Rejected requests keep the previous address/data so
    // the memory-side outputs do not move for them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            ctrl_q <= '{we: req_we, size: req_size, sgn: req_signed, err: req_err};
            if (!req_err) begin
                addr_q  <= req_addr_eff;
                wdata_q <= req_wdata;
            end
        end
    end

    // Load result register; only a completing load updates it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                      rdata_q <= '0;
        else if ((state_q == ST_DATA) && !ctrl_q.we)  rdata_q <= load_data;
    end

    assign resp_rdata = rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// ----------------------------------------------------------------------------
// tb_load_store_unit
//   Randomized scoreboard bench for load_store_unit. The reference model is a
//   byte-addressed array; expected responses are queued at issue time and a
//   negedge monitor pops them when resp_valid appears.
// ----------------------------------------------------------------------------
module tb_load_store_unit;

    localparam int DW = 32;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [1:0]    req_size = 2'b00;
    logic          req_signed = 1'b0;
    logic [AW+1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          resp_valid;
    logic [DW-1:0] resp_rdata;
    logic          resp_err;
    logic [AW-1:0] mem_addr;
    logic          mem_wr_rd;
    logic [DW-1:0] mem_data_in;
    logic [DW-1:0] mem_data_out;

    load_store_unit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_signed   (req_signed),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_addr     (mem_addr),
        .mem_wr_rd    (mem_wr_rd),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out)
    );

    always #5 clk = ~clk;

    // Memory: registered address, write goes to the previously registered address.
    logic [DW-1:0] mem [1024];
    logic [AW-1:0] mem_addr_q = '0;
    always @(posedge clk) begin
        if (mem_wr_rd == 1'b0) mem[mem_addr_q] = mem_data_in;
        mem_addr_q <= mem_addr;
    end
    assign mem_data_out = mem[mem_addr_q];

    // Reference model state.
    logic [7:0]  ref_b [4096];
    logic [31:0] last_rdata = '0;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          cyc;
        int          wr;
    } exp_t;
    exp_t q[$];

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int wr_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural rules: size 3 rejected; misaligned either rejected or
    // rounded down; loads gather little-endian bytes and extend.
    task automatic model(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [11:0] addr, input logic [31:0] wdata,
                         output logic err, output logic [31:0] rdata);
        int a = int'(addr);
        int nb;
        logic [31:0] v = '0;
        err = (size == 2'd3);
`ifdef LSU_ALIGN_CHECK_EN
        if (size == 2'd1 && (a % 2) != 0) err = 1'b1;
        if (size == 2'd2 && (a % 4) != 0) err = 1'b1;
`else
        if (size == 2'd1) a = a - (a % 2);
        if (size == 2'd2) a = a - (a % 4);
`endif
        nb = 1 << size;
        if (!err) begin
            if (we) begin
                for (int i = 0; i < nb; i++) ref_b[a+i] = wdata[8*i +: 8];
            end else begin
                for (int i = 0; i < nb; i++) v = v | (32'(ref_b[a+i]) << (8*i));
                if (sgn && nb < 4 && v[8*nb-1]) v = v | ~((32'h1 << (8*nb)) - 32'h1);
                last_rdata = v;
            end
        end
        rdata = last_rdata;
    endtask

    task automatic drive_junk();
        req_valid  = 1'($urandom);
        req_we     = 1'($urandom);
        req_size   = 2'($urandom);
        req_signed = 1'($urandom);
        req_addr   = 12'($urandom);
        req_wdata  = $urandom;
    endtask

    // Called at a negedge; returns at a negedge after the accept edge.
    task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [11:0] addr, input logic [31:0] wdata);
        exp_t e;
        int   waited = 0;
        while (req_ready !== 1'b1) begin
            drive_junk();
            @(negedge clk);
            waited++;
            if (waited > 20) begin
                check("ready_timeout", 32'(req_ready), 32'd1);
                return;
            end
        end
        req_valid  = 1'b1;
        req_we     = we;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
        model(we, size, sgn, addr, wdata, e.err, e.rdata);
        e.cyc = cyc;
        e.wr  = (we && !e.err) ? 1 : 0;
        q.push_back(e);
        @(negedge clk);
        drive_junk();
    endtask

    // Monitor / scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_wr_rd == 1'b0) wr_cnt++;
            if (resp_valid) begin
                if (q.size() == 0) begin
                    check("unexpected_resp", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("resp_err", 32'(resp_err), 32'(e.err));
                    check("resp_rdata", resp_rdata, e.rdata);
                    check("latency", 32'(cyc - e.cyc), e.err ? 32'd1 : 32'd3);
                    check("write_cycles", 32'(wr_cnt), 32'(e.wr));
                end
                wr_cnt = 0;
            end
        end
    end

    initial begin
        for (int w = 0; w < 1024; w++) mem[w] = (w < 16) ? $urandom : 32'h0;
        mem[5] = 32'h8899AABB;
        for (int w = 0; w < 1024; w++)
            for (int b = 0; b < 4; b++) ref_b[4*w+b] = mem[w][8*b +: 8];

        // Reset values.
        #3;
        check("rst_req_ready",   32'(req_ready),  32'd1);
        check("rst_resp_valid",  32'(resp_valid), 32'd0);
        check("rst_resp_err",    32'(resp_err),   32'd0);
        check("rst_resp_rdata",  resp_rdata,      32'd0);
        check("rst_mem_wr_rd",   32'(mem_wr_rd),  32'd1);
        check("rst_mem_addr",    32'(mem_addr),   32'd0);
        check("rst_mem_data_in", mem_data_in,     32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases on word 5.
        issue(1'b0, 2'b00, 1'b1, 12'h016, 32'h0);         // -> FFFFFF99
        issue(1'b0, 2'b01, 1'b0, 12'h014, 32'h0);         // -> 0000AABB
        issue(1'b1, 2'b00, 1'b0, 12'h017, 32'hFFFFFF5A);  // store byte 5A
        issue(1'b0, 2'b10, 1'b0, 12'h014, 32'h0);         // -> 5A99AABB
        issue(1'b0, 2'b10, 1'b0, 12'h015, 32'h0);         // misaligned word
        issue(1'b1, 2'b11, 1'b0, 12'h014, 32'h12345678);  // reserved size store
        issue(1'b0, 2'b11, 1'b1, 12'h014, 32'h0);         // reserved size load
        issue(1'b1, 2'b01, 1'b0, 12'h01B, 32'h0000C0DE);  // half store, odd addr
        issue(1'b0, 2'b01, 1'b1, 12'h01A, 32'h0);

        // Reset during store DATA: no write, no response.
        while (req_ready !== 1'b1) @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10;
        req_addr = 12'h010; req_wdata = 32'hDEADBEEF;
        @(negedge clk);                 // ADDR
        req_valid = 1'b0;
        @(posedge clk);                 // now DATA
        #2 rst = 1'b1;
        #1;
        check("abort_resp_valid", 32'(resp_valid), 32'd0);
        check("abort_mem_wr_rd",  32'(mem_wr_rd),  32'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        last_rdata = '0;
        @(negedge clk);
        check("abort_req_ready", 32'(req_ready), 32'd1);
        check("abort_word4", mem[4], {ref_b[19], ref_b[18], ref_b[17], ref_b[16]});

        // Random traffic over words 0..15.
        for (int n = 0; n < 200; n++)
            issue(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom),
                  12'($urandom_range(0, 63)), $urandom);

        req_valid = 1'b0;
        for (int k = 0; k < 50 && q.size() > 0; k++) @(negedge clk);
        check("drain", 32'(q.size()), 32'd0);

        for (int w = 0; w < 16; w++)
            check($sformatf("mem_word%0d", w), mem[w],
                  {ref_b[4*w+3], ref_b[4*w+2], ref_b[4*w+1], ref_b[4*w]});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
